// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer: FSM state encoding and counter width.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output register for a demux channel; a load in the same cycle as a drain
// keeps the channel valid so a streaming packet runs at one beat per cycle.
module demux_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              free
);

    assign free = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= d_data;
            m_last  <= d_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N packet demultiplexer: destination is latched on the first beat and held until
// s_last; packets addressed beyond the last channel are swallowed and counted.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int N_OUT  = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic [SEL_W-1:0]        s_sel,
    input  logic                    s_last,
    output logic [N_OUT-1:0]        m_valid,
    input  logic [N_OUT-1:0]        m_ready,
    output logic [N_OUT*DATA_W-1:0] m_data,
    output logic [N_OUT-1:0]        m_last,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam logic [SEL_W:0] N_OUT_V = (SEL_W + 1)'(N_OUT);

    state_t           state;
    logic [SEL_W-1:0] cur_sel;
    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] load;
    logic             sel_ok;
    logic             accept;
    logic             tgt_en;
    logic [SEL_W-1:0] tgt_sel;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sel_ok = ({1'b0, s_sel} < N_OUT_V);

    // s_ready never looks at s_valid, so there is no valid->ready loop upstream.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_IDLE: s_ready = sel_ok ? free[s_sel] : 1'b1;
            ST_PASS: s_ready = free[cur_sel];
            ST_DROP: s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    assign accept  = s_valid && s_ready;
    assign tgt_en  = accept && (((state == ST_IDLE) && sel_ok) || (state == ST_PASS));
    assign tgt_sel = (state == ST_PASS) ? cur_sel : s_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_sel  <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (sel_ok) begin
                        cur_sel <= s_sel;
                        if (!s_last) state <= ST_PASS;
                    end else begin
                        drop_cnt <= sat_inc(drop_cnt);
                        if (!s_last) state <= ST_DROP;
                    end
                end
                ST_PASS, ST_DROP: begin
                    if (s_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        assign load[k] = tgt_en && (tgt_sel == SEL_W'(k));

        demux_out_reg #(.DATA_W(DATA_W)) u_reg (
            .clk     (clk),
            .rst     (rst),
            .load    (load[k]),
            .d_data  (s_data),
            .d_last  (s_last),
            .m_ready (m_ready[k]),
            .m_valid (m_valid[k]),
            .m_data  (m_data[k*DATA_W +: DATA_W]),
            .m_last  (m_last[k]),
            .free    (free[k])
        );
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-N stream demultiplexer, the inverse of the team's 2:1 selector: one valid/ready input stream is steered to one of N output streams by a select field. Selection is sampled on the first beat of a packet and held until the beat carrying `s_last`, so packets never interleave across outputs. Sits downstream of the selector datapath, fanning a shared bus out to per-consumer channels.

## Interface
- `N_OUT`, 4, number of output channels (2..16)
- `DATA_W`, 8, payload width
- `SEL_W`, `$clog2(N_OUT)` (min 1), derived select width; not overridden
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat accepted when `s_valid & s_ready`
- `s_data`  in  DATA_W  input payload
- `s_sel`  in  SEL_W  destination channel, sampled on first beat of packet only
- `s_last`  in  1  final beat of packet
- `m_valid`  out  N_OUT  per-channel output valid
- `m_ready`  in  N_OUT  per-channel output ready
- `m_data`  out  N_OUT*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- `m_last`  out  N_OUT  per-channel last flag
- `drop_cnt`  out  8  count of dropped packets, saturates at 255

## Operation
- FSM states: IDLE (no packet open), PASS (locked to channel `cur_sel`), DROP (discarding packet).
- IDLE, accepted beat with `s_sel < N_OUT`: beat written to channel `s_sel`; `cur_sel <= s_sel`; go PASS unless `s_last`, then stay IDLE.
- IDLE, accepted beat with `s_sel >= N_OUT`: beat discarded; `drop_cnt` increments (saturating); go DROP unless `s_last`, then stay IDLE.
- PASS: `s_sel` ignored; every accepted beat goes to `cur_sel`; beat with `s_last` returns to IDLE.
- DROP: `s_ready = 1`; beats discarded; beat with `s_last` returns to IDLE.
- Each channel has one output register (valid/data/last). Channel k is free when `!m_valid[k] | m_ready[k]`.
- `s_ready` in IDLE = channel selected by `s_sel` is free, or `s_sel >= N_OUT`; in PASS = channel `cur_sel` is free.
- Channel k register: loads on accepted beat targeting k; otherwise clears `m_valid[k]` when `m_ready[k]`. Load and drain in the same cycle: load wins, `m_valid[k]` stays 1 (full throughput).
- Non-target channels are unaffected by input traffic and drain independently.
- `m_data`/`m_last` hold their value while `m_valid` is low; there is no requirement on content.

## Timing
- Reset values: state IDLE, `cur_sel` 0, all `m_valid` 0, `m_data` 0, `m_last` 0, `drop_cnt` 0; `s_ready` follows IDLE rule combinationally.
- Latency: beat accepted in cycle t appears on `m_*` in cycle t+1.
- Throughput: one beat per cycle per open packet when target `m_ready` is held high.
- `s_ready` is combinational from `s_sel`, state, `m_valid`, `m_ready`. `m_*` are registered outputs.
- No combinational path from `s_valid` to `s_ready`.
- `rst` mid-packet: FSM to IDLE, all output registers invalidated, and in-flight beats are lost. The next accepted beat is treated as a packet start.
- Single-beat packet (`s_last` on the first beat): no PASS/DROP state is entered.
- Upstream must hold `s_data/s_sel/s_last` stable while `s_valid & !s_ready`. The bench checks this; the RTL does not.

## Structure
- Shared package `stream_demux_pkg`: state enum (`ST_IDLE`, `ST_PASS`, `ST_DROP`), `DROP_CNT_W = 8`.
- Sub-module `demux_out_reg` (one-entry valid/data/last register with load/drain), instantiated N_OUT times in a generate loop.
- Top holds the FSM, `cur_sel`, `s_ready` decode, and drop counter.

## Test plan
- Reset, then 3-beat packet to sel=2 (data 0x11,0x22,0x33, last on 3rd) with all `m_ready`=1 -> `m_valid[2]` high cycles t+1..t+3, data 0x11/0x22/0x33, `m_last[2]` only with 0x33; other channels never valid.
- Packet to sel=1 with `s_sel` toggled to 3 on beats 2..4 -> all 4 beats on channel 1; channel 3 untouched.
- `m_ready[0]`=0 while sending 2 beats to sel=0 -> first beat held on `m_data[0]`, `s_ready` low; raise `m_ready[0]` -> second beat follows next cycle, no loss or duplication.
- N_OUT=3, packet with sel=3 (4 beats) -> `s_ready`=1 throughout, no `m_valid`, `drop_cnt` 0->1; 300 such packets -> `drop_cnt` stops at 255.
- Assert `rst` on beat 2 of a 4-beat packet to sel=1 -> next cycle all `m_valid`=0 and state IDLE; next beat with sel=0 routes to channel 0.
- Back-to-back single-beat packets to sel=0,1,2,3 with all ready -> one beat per cycle, each on its own channel, `s_ready` never drops.
